param_main_memory: RTL and testbench

Parametrised single-port main memory and the successor to the fixed 16-bit × 64K main memory. It adds configurable width and depth, per-byte write strobes, a valid/ready request handshake and a configurable read latency. It also replaces the single-cycle whole-array reset with a sequential clear engine that zeroes one word per cycle. It sits between the processor's load/store unit and the memory array.

---
 rtl/param_main_memory_pkg.sv | 19 +
 rtl/param_main_memory_read_pipe.sv | 44 ++++
 rtl/param_main_memory.sv | 117 +++++++++++
 tb/tb_param_main_memory.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_main_memory_pkg.sv
// mem_pkg: shared types and constants for param_main_memory.
//   mem_state_t  - controller state (INIT clears the array, READY serves requests)
//   MIN_RD_LAT / MAX_RD_LAT - legal READ_LATENCY range
//   strb_width() - number of byte strobes for a given word width
package mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 4;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/param_main_memory_read_pipe.sv
// mem_read_pipe: valid/data delay line for read responses.
//   clk, reset   - clock, synchronous active-high flush
//   in_valid     - read sampled at this edge
//   in_data      - word sampled at this edge
//   out_valid    - one-cycle pulse STAGES edges after the sampling edge
//   out_data     - response word; holds its last value between pulses
module mem_read_pipe #(
    parameter int DATA_W = 16,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Stage 0 is the sample register loaded at the accepting edge;
    // stages 1..STAGES add the configured latency on top of it.
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][DATA_W-1:0] data_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            if (in_valid)
                data_pipe[0] <= in_data;
            // Data only moves with a valid token, so the last stage holds
            // the previous response while nothing is in flight.
            for (int k = 1; k <= STAGES; k++) begin
                if (vld_pipe[k-1])
                    data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];

endmodule

// File: rtl/param_main_memory.sv
// param_main_memory: single-port word-addressed memory with byte strobes,
// valid/ready request handshake, configurable read latency and a
// sequential post-reset clear engine.
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only once cleared)
//   req_write           - 1 = write, 0 = read
//   req_addr            - word address
//   req_wdata/req_wstrb - write data and per-byte enables
//   rsp_valid/rsp_rdata - read response, READ_LATENCY edges after acceptance
//   init_done           - array fully cleared since last reset
module param_main_memory
    import mem_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_done
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int STRB_W = strb_width(DATA_W);

    if ((DATA_W % 8) != 0 || READ_LATENCY < MIN_RD_LAT || READ_LATENCY > MAX_RD_LAT) begin : g_bad_param
        $error("param_main_memory: DATA_W must be a multiple of 8 and READ_LATENCY within 1..4");
    end

    mem_state_t state_q, state_d;

    // One extra bit so the count past the last address never wraps to 0.
    logic [ADDR_W:0]   clr_cnt;
    logic              clr_last;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged_word;
    logic              accept;
    logic              wr_fire;
    logic              rd_fire;

    assign req_ready = (state_q == READY);
    assign init_done = (state_q == READY);

    assign accept   = req_valid && req_ready;
    assign wr_fire  = accept && req_write;
    assign rd_fire  = accept && !req_write;
    assign clr_last = (clr_cnt == (ADDR_W+1)'(DEPTH - 1));

    // ---------------- controller ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (clr_last) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= INIT;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset)
            clr_cnt <= '0;
        else if (state_q == INIT)
            clr_cnt <= clr_cnt + 1'b1;
    end

    // ---------------- array ----------------
    assign cur_word = mem[req_addr];

    // Unstrobed bytes keep the current contents.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b])
                merged_word[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    // The clear engine owns the port during INIT; requests cannot be
    // accepted then, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (!reset && state_q == INIT)
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
        else if (!reset && wr_fire)
            mem[req_addr] <= merged_word;
    end

    // ---------------- read response ----------------
    mem_read_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_data   (cur_word),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata)
    );

endmodule

// File: tb/tb_param_main_memory.sv
// Bench for param_main_memory: three instances (16b/lat2, 32b/lat1,
// 16b/lat4) share one request stream; each read carries a hand-computed
// expected word that is scheduled per instance at its own latency.
module tb_param_main_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic [2:0]        rdy, rv, idn;
    logic [15:0]       rd0, rd2;
    logic [31:0]       rd1;
    logic [2:0][31:0]  rdat;

    assign rdat[0] = {16'h0, rd0};
    assign rdat[1] = rd1;
    assign rdat[2] = {16'h0, rd2};

    param_main_memory #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata[15:0]),
        .req_wstrb(req_wstrb[1:0]), .rsp_valid(rv[0]), .rsp_rdata(rd0), .init_done(idn[0]));

    param_main_memory #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rv[1]), .rsp_rdata(rd1), .init_done(idn[1]));

    param_main_memory #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata[15:0]),
        .req_wstrb(req_wstrb[1:0]), .rsp_valid(rv[2]), .rsp_rdata(rd2), .init_done(idn[2]));

    localparam int LAT [3] = '{2, 1, 4};

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    typedef struct {
        bit          w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] e;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mrdy  = 1'b0;
    int          icnt  = 0;
    logic [31:0] exp_rd [3];
    logic [31:0] cur_exp;
    pend_t       pq [3][$];
    vec_t        tbl [13];

    function automatic logic [31:0] msk(input int k);
        return (k == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // One clock: update the reference at the edge, compare at the falling edge.
    task automatic tick();
        logic ev;
        @(posedge clk);
        cyc++;
        if (reset) begin
            mrdy = 1'b0;
            icnt = 0;
            for (int k = 0; k < 3; k++) begin
                pq[k].delete();
                exp_rd[k] = '0;
            end
        end else begin
            if (mrdy && req_valid && !req_write)
                for (int k = 0; k < 3; k++)
                    pq[k].push_back('{cyc + LAT[k], cur_exp & msk(k)});
            if (!mrdy) begin
                icnt++;
                if (icnt == 16) mrdy = 1'b1;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ev = 1'b0;
            if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                ev = 1'b1;
                exp_rd[k] = pq[k][0].d;
                void'(pq[k].pop_front());
            end
            chk($sformatf("rsp_valid[%0d]", k), {31'b0, rv[k]}, {31'b0, ev});
            chk($sformatf("rsp_rdata[%0d]", k), rdat[k], exp_rd[k]);
            chk($sformatf("req_ready[%0d]", k), {31'b0, rdy[k]}, {31'b0, mrdy});
            chk($sformatf("init_done[%0d]", k), {31'b0, idn[k]}, {31'b0, mrdy});
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = 32'hDEAD_BEEF;   // must be ignored on reads
        req_wstrb = 4'hF;
        cur_exp   = e;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        tick();
    endtask

    task automatic nop(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Holds a write to addr 5 on the bus while clearing; it must be dropped.
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF;
        while (!rdy[0] && n < 40) begin
            tick();
            n++;
        end
        idle();
        chk(nm, n, 16);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        cur_exp   = '0;
        for (int k = 0; k < 3; k++) exp_rd[k] = '0;

        tbl[0]  = '{1'b1, 4'd3,  32'h1111_ABCD, 4'b1111, 32'h0};
        tbl[1]  = '{1'b1, 4'd3,  32'h2222_1234, 4'b0101, 32'h0};
        tbl[2]  = '{1'b0, 4'd3,  32'h0,         4'b0000, 32'h1122_AB34};
        tbl[3]  = '{1'b1, 4'd3,  32'hFFFF_FFFF, 4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 4'd3,  32'h0,         4'b0000, 32'h1122_AB34};
        tbl[5]  = '{1'b1, 4'd3,  32'h9988_7766, 4'b1010, 32'h0};
        tbl[6]  = '{1'b0, 4'd3,  32'h0,         4'b0000, 32'h9922_7734};
        tbl[7]  = '{1'b1, 4'd7,  32'h0000_5A5A, 4'b1111, 32'h0};
        tbl[8]  = '{1'b0, 4'd7,  32'h0,         4'b0000, 32'h0000_5A5A};
        tbl[9]  = '{1'b0, 4'd0,  32'h0,         4'b0000, 32'h0};
        tbl[10] = '{1'b1, 4'd15, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        tbl[11] = '{1'b0, 4'd15, 32'h0,         4'b0000, 32'hDEAD_BEEF};
        tbl[12] = '{1'b0, 4'd3,  32'h0,         4'b0000, 32'h9922_7734};

        // Reset state and first clear.
        tick();
        reset = 1'b0;
        wait_init("init_len_first");

        // Fill with nonzero data, then reset and confirm the array is rezeroed.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'hFFFF_FF00 | 32'(a), 4'hF);
        rd(4'd9, 32'hFFFF_FF09);
        do_reset();
        wait_init("init_len_after_fill");
        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
        nop(5);

        // Strobe / ordering vectors, back to back.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d, tbl[i].s);
            else          rd(tbl[i].a, tbl[i].e);
        end
        nop(5);

        // Streaming reads at full throughput.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'(a) * 32'h0101_0101, 4'hF);
        for (int a = 0; a < 16; a++) rd(4'(a), 32'(a) * 32'h0101_0101);
        nop(6);

        // Reset with reads in flight: responses dropped, clear restarts.
        rd(4'd1, 32'h0101_0101);
        rd(4'd2, 32'h0202_0202);
        do_reset();
        wait_init("init_len_mid_op");
        rd(4'd1, 32'h0);
        rd(4'd2, 32'h0);
        rd(4'd7, 32'h0);
        nop(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
